// File: rtl/acp_dma_pkg.sv
// acp_dma_pkg: register offsets, DataMover command field layout, status
// error mask and the read value returned for unmapped locations.
package acp_dma_pkg;

    localparam logic [7:0] OFF_ADDR = 8'h00;
    localparam logic [7:0] OFF_CTRL = 8'h04;
    localparam logic [7:0] OFF_STAT = 8'h08;
    localparam logic [7:0] OFF_POP  = 8'h0C;
    localparam logic [7:0] OFF_DONE = 8'h10;
    localparam logic [7:0] OFF_IEN  = 8'h14;

    localparam int CMD_W        = 72;
    localparam int STS_W        = 8;
    localparam int CMD_BTT_LSB  = 0;
    localparam int CMD_BTT_W    = 23;
    localparam int CMD_TYPE_BIT = 23;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_ADDR_LSB = 32;
    localparam int CMD_TAG_LSB  = 64;
    localparam int CMD_TAG_W    = 4;

    // INTERR / DECERR / SLVERR bits of a DataMover status byte
    localparam logic [STS_W-1:0] STS_ERR_MASK = 8'h70;
    localparam logic [31:0]      BAD_DATA     = 32'hDEAD_BEEF;

    // Build a command word from a CTRL write (tag/eof/btt) and the staged address.
    function automatic logic [CMD_W-1:0] mk_cmd(input logic [31:0] ctrl, input logic [31:0] addr);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_BTT_LSB +: CMD_BTT_W] = ctrl[22:0];
        c[CMD_TYPE_BIT]             = 1'b1;
        c[CMD_EOF_BIT]              = ctrl[23];
        c[CMD_ADDR_LSB +: 32]       = addr;
        c[CMD_TAG_LSB +: CMD_TAG_W] = ctrl[27:24];
        return c;
    endfunction

endpackage

// File: rtl/acp_dma_fifo.sv
// acp_dma_fifo: synchronous FIFO with occupancy count. A push while full is
// accepted when a pop happens in the same cycle.
module acp_dma_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rptr];

    // pointers and occupancy; count never exceeds DEPTH because push_ok gates on full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // storage array, no reset needed since empty masks stale entries
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/acp_dma_ctrl.sv
// acp_dma_ctrl: N-channel DataMover command/status engine behind the set/get
// register bus. Optional feature macro: ACP_DMA_IRQ_EN (IEN register + irq).
module acp_dma_ctrl
    import acp_dma_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_CH           = 2,
    parameter int C_PAGEWIDTH        = 16,
    parameter int C_CMD_DEPTH        = 4,
    parameter int C_STS_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
    input  logic                          set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
    input  logic                          get_stb,
    output logic [C_NUM_CH-1:0]           M_AXIS_CMD_TVALID,
    input  logic [C_NUM_CH-1:0]           M_AXIS_CMD_TREADY,
    output logic [CMD_W*C_NUM_CH-1:0]     M_AXIS_CMD_TDATA,
    input  logic [C_NUM_CH-1:0]           S_AXIS_STS_TVALID,
    output logic [C_NUM_CH-1:0]           S_AXIS_STS_TREADY,
    input  logic [STS_W*C_NUM_CH-1:0]     S_AXIS_STS_TDATA,
    output logic [C_NUM_CH-1:0]           irq
);
    localparam int CH_BITS = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
    localparam int CCW     = $clog2(C_CMD_DEPTH) + 1;
    localparam int SCW     = $clog2(C_STS_DEPTH) + 1;

    logic [CH_BITS-1:0]        set_ch, get_ch;
    logic [7:0]                set_off, get_off;
    logic                      live;
    logic [C_NUM_CH-1:0][31:0] rd_word;
    logic                      unused_addr;

    assign set_ch      = set_addr[C_PAGEWIDTH +: CH_BITS];
    assign get_ch      = get_addr[C_PAGEWIDTH +: CH_BITS];
    assign set_off     = set_addr[7:0];
    assign get_off     = get_addr[7:0];
    assign unused_addr = ^{set_addr, get_addr};

    // status ready is held low while in reset and for the first cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // read mux; channels beyond C_NUM_CH fall through to BAD_DATA
    always_comb begin
        get_data = BAD_DATA;
        for (int i = 0; i < C_NUM_CH; i++)
            if (int'(get_ch) == i) get_data = rd_word[i];
    end

    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
        localparam logic [CH_BITS-1:0] IDX = CH_BITS'(i);

        logic             wsel, rsel, wr_addr, wr_ctrl, wr_done, rd_stat, rd_pop;
        logic             cmd_full, cmd_empty, cmd_pop;
        logic             sts_full, sts_empty, sts_push;
        logic [CCW-1:0]   cmd_cnt;
        logic [SCW-1:0]   sts_cnt;
        logic [STS_W-1:0] sts_in, sts_dout, sts_head;
        logic [31:0]      addr_q, ctrl_q, ien_word, word;
        logic [15:0]      done_q;
        logic             ovf, sts_err;

        assign wsel    = set_stb && (set_ch == IDX);
        assign rsel    = get_stb && (get_ch == IDX);
        assign wr_addr = wsel && (set_off == OFF_ADDR);
        assign wr_ctrl = wsel && (set_off == OFF_CTRL);
        assign wr_done = wsel && (set_off == OFF_DONE);
        assign rd_stat = rsel && (get_off == OFF_STAT);
        assign rd_pop  = rsel && (get_off == OFF_POP);

        assign M_AXIS_CMD_TVALID[i] = !cmd_empty;
        assign cmd_pop              = M_AXIS_CMD_TVALID[i] && M_AXIS_CMD_TREADY[i];

        acp_dma_fifo #(.WIDTH(CMD_W), .DEPTH(C_CMD_DEPTH)) u_cmd (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (wr_ctrl),
            .pop   (cmd_pop),
            .din   (mk_cmd(set_data, addr_q)),
            .dout  (M_AXIS_CMD_TDATA[CMD_W*i +: CMD_W]),
            .full  (cmd_full),
            .empty (cmd_empty),
            .count (cmd_cnt)
        );

        assign sts_in               = S_AXIS_STS_TDATA[STS_W*i +: STS_W];
        assign S_AXIS_STS_TREADY[i] = live && !sts_full;
        assign sts_push             = S_AXIS_STS_TVALID[i] && S_AXIS_STS_TREADY[i];
        assign sts_head             = sts_empty ? '0 : sts_dout;

        acp_dma_fifo #(.WIDTH(STS_W), .DEPTH(C_STS_DEPTH)) u_sts (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (sts_push),
            .pop   (rd_pop),
            .din   (sts_in),
            .dout  (sts_dout),
            .full  (sts_full),
            .empty (sts_empty),
            .count (sts_cnt)
        );

        // channel registers; a completion arriving with a DONE write leaves DONE at 1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_q  <= '0;
                ctrl_q  <= '0;
                done_q  <= '0;
                ovf     <= 1'b0;
                sts_err <= 1'b0;
            end else begin
                if (wr_addr) addr_q <= set_data;
                if (wr_ctrl) ctrl_q <= set_data;
                if (wr_ctrl && cmd_full && !cmd_pop) ovf <= 1'b1;
                else if (rd_stat)                    ovf <= 1'b0;
                if (sts_push)     done_q <= wr_done ? 16'd1 : done_q + 16'd1;
                else if (wr_done) done_q <= '0;
                if (sts_push && |(sts_in & STS_ERR_MASK)) sts_err <= 1'b1;
                else if (wr_done)                         sts_err <= 1'b0;
            end
        end

`ifdef ACP_DMA_IRQ_EN
        logic wr_ien, ien, irq_q;
        assign wr_ien   = wsel && (set_off == OFF_IEN);
        assign ien_word = {31'b0, ien};
        assign irq[i]   = irq_q;

        // irq level follows status occupancy one cycle late
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ien   <= 1'b0;
                irq_q <= 1'b0;
            end else begin
                if (wr_ien) ien <= set_data[0];
                irq_q <= ien && !sts_empty;
            end
        end
`else
        assign ien_word = '0;
        assign irq[i]   = 1'b0;
`endif

        // per-channel read word for the addressed offset
        always_comb begin
            word = BAD_DATA;
            case (get_off)
                OFF_ADDR: word = addr_q;
                OFF_CTRL: word = ctrl_q;
                OFF_STAT: word = {8'(cmd_cnt), 8'(sts_cnt), 5'b0, ovf, sts_err, !sts_empty, sts_head};
                OFF_POP:  word = {24'b0, sts_head};
                OFF_DONE: word = {16'b0, done_q};
                OFF_IEN:  word = ien_word;
                default:  word = BAD_DATA;
            endcase
        end
        assign rd_word[i] = word;
    end

endmodule

// File: tb/tb_acp_dma_ctrl.sv
// tb_acp_dma_ctrl: directed checks of acp_dma_ctrl with 3 channels so that
// channel index 3 is an out-of-range page. IRQ checks follow ACP_DMA_IRQ_EN.
module tb_acp_dma_ctrl;
    localparam int NCH = 3;
    localparam logic [7:0] O_ADDR = 8'h00, O_CTRL = 8'h04, O_STAT = 8'h08;
    localparam logic [7:0] O_POP = 8'h0C, O_DONE = 8'h10, O_IEN = 8'h14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       set_addr, set_data, get_addr, get_data;
    logic              set_stb, get_stb;
    logic [NCH-1:0]    cmd_tvalid, cmd_tready, sts_tvalid, sts_tready, irq;
    logic [72*NCH-1:0] cmd_tdata;
    logic [8*NCH-1:0]  sts_tdata;
    logic [31:0]       d;
    int                n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    acp_dma_ctrl #(.C_NUM_CH(NCH)) dut (
        .clk(clk), .rst_n(rst_n),
        .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
        .get_addr(get_addr), .get_data(get_data), .get_stb(get_stb),
        .M_AXIS_CMD_TVALID(cmd_tvalid), .M_AXIS_CMD_TREADY(cmd_tready), .M_AXIS_CMD_TDATA(cmd_tdata),
        .S_AXIS_STS_TVALID(sts_tvalid), .S_AXIS_STS_TREADY(sts_tready), .S_AXIS_STS_TDATA(sts_tdata),
        .irq(irq)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ra(input int ch, input logic [7:0] off);
        return (32'(ch) << 16) | {24'h0, off};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        set_addr = a; set_data = v; set_stb = 1'b1;
        @(posedge clk); #1 set_stb = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input bit stb, output logic [31:0] v);
        get_addr = a; get_stb = stb;
        #1 v = get_data;
        if (stb) begin
            @(posedge clk); #1 get_stb = 1'b0;
        end
    endtask

    task automatic sts(input int ch, input logic [7:0] v);
        sts_tvalid[ch] = 1'b1; sts_tdata[8*ch +: 8] = v;
        @(posedge clk); #1 sts_tvalid[ch] = 1'b0;
    endtask

    initial begin
        set_addr = '0; set_data = '0; set_stb = 1'b0;
        get_addr = '0; get_stb = 1'b0;
        cmd_tready = '0; sts_tvalid = '0; sts_tdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 72'(cmd_tvalid), 72'h0);
        chk("rst_tready", 72'(sts_tready), 72'h0);
        chk("rst_irq", 72'(irq), 72'h0);
        rd(ra(0, O_STAT), 0, d); chk("rst_stat", 72'(d), 72'h0);
        rd(ra(1, O_DONE), 0, d); chk("rst_done", 72'(d), 72'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("run_tready", 72'(sts_tready), 72'h7);

        // single command on ch1
        wr(ra(1, O_ADDR), 32'h1000_0000);
        chk("cmd_idle", 72'(cmd_tvalid[1]), 72'h0);
        rd(ra(1, O_ADDR), 0, d); chk("addr_rb", 72'(d), 72'h1000_0000);
        wr(ra(1, O_CTRL), 32'h0380_0100);
        chk("cmd_tvalid", 72'(cmd_tvalid[1]), 72'h1);
        chk("cmd_tdata", cmd_tdata[72 +: 72], 72'h03_10000000_40800100);
        rd(ra(1, O_CTRL), 0, d); chk("ctrl_rb", 72'(d), 72'h0380_0100);
        cmd_tready[1] = 1'b1;
        @(posedge clk); #1 cmd_tready[1] = 1'b0;
        chk("cmd_drained", 72'(cmd_tvalid[1]), 72'h0);

        // overflow: five writes into a depth-4 FIFO with no ready
        for (int k = 1; k <= 5; k++) wr(ra(1, O_CTRL), 32'(k));
        rd(ra(1, O_STAT), 1, d); chk("ovf_stat", 72'(d), 72'h0400_0400);
        rd(ra(1, O_STAT), 0, d); chk("ovf_clr", 72'(d), 72'h0400_0000);
        // push accepted into a full FIFO when a pop happens the same cycle
        cmd_tready[1] = 1'b1;
        set_addr = ra(1, O_CTRL); set_data = 32'd6; set_stb = 1'b1;
        @(posedge clk); #1 set_stb = 1'b0; cmd_tready[1] = 1'b0;
        rd(ra(1, O_STAT), 0, d); chk("full_pushpop", 72'(d), 72'h0400_0000);
        cmd_tready[1] = 1'b1;
        begin
            logic [22:0] exp_btt [4];
            exp_btt = '{23'd2, 23'd3, 23'd4, 23'd6};
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("drain_btt%0d", k), 72'(cmd_tdata[72 +: 23]), 72'(exp_btt[k]));
                @(posedge clk); #1;
            end
        end
        cmd_tready[1] = 1'b0;
        chk("drain_empty", 72'(cmd_tvalid[1]), 72'h0);

        // status queue on ch0
        sts(0, 8'h80);
        sts(0, 8'hC0);
        rd(ra(0, O_STAT), 0, d); chk("sts_stat", 72'(d), 72'h0002_0380);
        rd(ra(0, O_DONE), 0, d); chk("sts_done", 72'(d), 72'h2);
        rd(ra(0, O_POP), 1, d); chk("pop0", 72'(d), 72'h80);
        rd(ra(0, O_POP), 1, d); chk("pop1", 72'(d), 72'hC0);
        rd(ra(0, O_STAT), 0, d); chk("sts_empty", 72'(d), 72'h0000_0200);
        rd(ra(0, O_POP), 1, d); chk("pop_empty", 72'(d), 72'h0);
        sts(0, 8'h81);
        sts_tvalid[0] = 1'b1; sts_tdata[7:0] = 8'h82;
        rd(ra(0, O_POP), 1, d); sts_tvalid[0] = 1'b0;
        chk("pop_push_rd", 72'(d), 72'h81);
        rd(ra(0, O_STAT), 0, d); chk("pop_push_stat", 72'(d), 72'h0001_0382);
        wr(ra(0, O_DONE), 32'h0);
        rd(ra(0, O_STAT), 0, d); chk("err_clr", 72'(d), 72'h0001_0182);
        rd(ra(0, O_DONE), 0, d); chk("done_clr", 72'(d), 72'h0);
        rd(ra(0, O_POP), 1, d); chk("pop_last", 72'(d), 72'h82);

        // status FIFO full on ch2 stops ready and counting
        for (int k = 0; k < 4; k++) sts(2, 8'h80);
        chk("sts_full_rdy", 72'(sts_tready[2]), 72'h0);
        sts(2, 8'h80);
        rd(ra(2, O_STAT), 0, d); chk("sts_full_stat", 72'(d), 72'h0004_0180);
        rd(ra(2, O_DONE), 0, d); chk("sts_full_done", 72'(d), 72'h4);
        for (int k = 0; k < 4; k++) rd(ra(2, O_POP), 1, d);
        chk("sts_unfull_rdy", 72'(sts_tready[2]), 72'h1);

        // DONE wraps at 0xFFFF
        sts(0, 8'h00);
        sts_tvalid[0] = 1'b1; sts_tdata[7:0] = 8'h00;
        get_addr = ra(0, O_POP); get_stb = 1'b1;
        repeat (65534) @(posedge clk);
        #1 sts_tvalid[0] = 1'b0; get_stb = 1'b0;
        rd(ra(0, O_DONE), 0, d); chk("done_ffff", 72'(d), 72'hFFFF);
        rd(ra(0, O_STAT), 0, d); chk("done_run_stat", 72'(d), 72'h0001_0100);
        sts(0, 8'h00);
        rd(ra(0, O_DONE), 0, d); chk("done_wrap", 72'(d), 72'h0);
        set_addr = ra(0, O_DONE); set_data = 32'h1234; set_stb = 1'b1;
        sts_tvalid[0] = 1'b1;
        @(posedge clk); #1 set_stb = 1'b0; sts_tvalid[0] = 1'b0;
        rd(ra(0, O_DONE), 0, d); chk("done_wr_inc", 72'(d), 72'h1);
        for (int k = 0; k < 3; k++) rd(ra(0, O_POP), 1, d);
        rd(ra(0, O_STAT), 0, d); chk("drain_stat0", 72'(d), 72'h0);

        // unmapped accesses
        rd(ra(3, O_ADDR), 0, d); chk("bad_ch", 72'(d), 72'hDEADBEEF);
        rd(ra(0, 8'h40), 0, d); chk("bad_off", 72'(d), 72'hDEADBEEF);
        wr(ra(3, O_CTRL), 32'h1);
        chk("bad_ch_wr", 72'(cmd_tvalid), 72'h0);

        // interrupt
`ifdef ACP_DMA_IRQ_EN
        wr(ra(0, O_IEN), 32'h1);
        rd(ra(0, O_IEN), 0, d); chk("ien_rb", 72'(d), 72'h1);
        sts(0, 8'h80);
        chk("irq_lag", 72'(irq[0]), 72'h0);
        @(posedge clk); #1;
        chk("irq_set", 72'(irq[0]), 72'h1);
        rd(ra(0, O_POP), 1, d);
        chk("irq_hold", 72'(irq[0]), 72'h1);
        @(posedge clk); #1;
        chk("irq_clr", 72'(irq[0]), 72'h0);
`else
        wr(ra(0, O_IEN), 32'h1);
        rd(ra(0, O_IEN), 0, d); chk("ien_rb", 72'(d), 72'h0);
        sts(0, 8'h80);
        @(posedge clk); #1;
        chk("irq_off", 72'(irq), 72'h0);
        rd(ra(0, O_POP), 1, d);
`endif

        // reset in the middle of queued work
        wr(ra(0, O_ADDR), 32'hABCD_0000);
        wr(ra(0, O_CTRL), 32'h10);
        wr(ra(0, O_CTRL), 32'h20);
        sts(0, 8'h80);
        chk("pre_rst_tvalid", 72'(cmd_tvalid[0]), 72'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 72'(cmd_tvalid), 72'h0);
        chk("mid_rst_tready", 72'(sts_tready), 72'h0);
        rd(ra(0, O_STAT), 0, d); chk("mid_rst_stat", 72'(d), 72'h0);
        rd(ra(0, O_ADDR), 0, d); chk("mid_rst_addr", 72'(d), 72'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_tvalid", 72'(cmd_tvalid), 72'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
